// File: rtl/ac_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the accumulator unit.
package ac_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_PASS = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NOT  = 4'd7,
    OP_INC  = 4'd8,
    OP_CLR  = 4'd9,
    OP_SHL  = 4'd10,
    OP_SHR  = 4'd11,
    OP_MUL  = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/ac_mul_seq.sv
// Unsigned shift-add multiplier: one step per cycle, WIDTH steps after start.
// product is the value after the current step; last_step flags the final one.
module ac_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last_step
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   sum;

  // Multiplier bits are consumed from lo_q[0] as the partial product shifts in from the top.
  assign sum       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
  assign product   = {sum[WIDTH:1], sum[0], lo_q[WIDTH-1:1]};
  assign last_step = (cnt_q == CNT_W'(1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else if (start) begin
      mcand_q <= multiplicand;
      hi_q    <= '0;
      lo_q    <= multiplier;
      cnt_q   <= CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      hi_q  <= product[2*WIDTH-1:WIDTH];
      lo_q  <= product[WIDTH-1:0];
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/ac_unit_param.sv
// Accumulator with inline ALU, ZNCV flags and optional multiplier (define AC_MUL_EN).
// ALU ops load 1 edge after AC_LOAD; MUL takes WIDTH+1 cycles and ignores AC_LOAD while BUSY/DONE.
module ac_unit_param
  import ac_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] BUS_IN,
  input  logic [3:0]       OP,
  input  logic             AC_LOAD,
  input  logic             AC_BUS,
  output logic [WIDTH-1:0] AC_BUS_OUT,
  output logic             AC_BUS_OE,
  output logic [WIDTH-1:0] AC_TOCPU,
  output logic [WIDTH-1:0] MQ_OUT,
  output logic             Z_TOCU,
  output logic             N_TOCU,
  output logic             C_TOCU,
  output logic             V_TOCU,
  output logic             BUSY,
  output logic             DONE
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] ac_q;
  logic [3:0]       flags_q;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic [WIDTH:0]   sum;
  logic             c_n;
  logic             v_n;
  logic             upd;

  always_comb begin
    alu_res   = ac_q;
    sum       = '0;
    c_n       = flags_q[FLAG_C];
    v_n       = flags_q[FLAG_V];
    upd       = 1'b1;
    case (OP)
      OP_PASS: alu_res = BUS_IN;
      OP_ADD: begin
        sum     = {1'b0, ac_q} + {1'b0, BUS_IN};
        alu_res = sum[WIDTH-1:0];
        c_n     = sum[WIDTH];
        v_n     = (ac_q[MSB] == BUS_IN[MSB]) && (alu_res[MSB] != ac_q[MSB]);
      end
      OP_SUB: begin
        sum     = {1'b0, ac_q} - {1'b0, BUS_IN};
        alu_res = sum[WIDTH-1:0];
        c_n     = sum[WIDTH];
        v_n     = (ac_q[MSB] != BUS_IN[MSB]) && (alu_res[MSB] != ac_q[MSB]);
      end
      OP_AND: alu_res = ac_q & BUS_IN;
      OP_OR:  alu_res = ac_q | BUS_IN;
      OP_XOR: alu_res = ac_q ^ BUS_IN;
      OP_NOT: alu_res = ~ac_q;
      OP_INC: begin
        sum     = {1'b0, ac_q} + (WIDTH+1)'(1);
        alu_res = sum[WIDTH-1:0];
        c_n     = sum[WIDTH];
        v_n     = ~ac_q[MSB] & alu_res[MSB];
      end
      OP_CLR: alu_res = '0;
      OP_SHL: begin
        alu_res = {ac_q[MSB-1:0], 1'b0};
        c_n     = ac_q[MSB];
      end
      OP_SHR: begin
        alu_res = {1'b0, ac_q[MSB:1]};
        c_n     = ac_q[0];
      end
      default: upd = 1'b0;
    endcase
    alu_flags = flags_q;
    if (upd) begin
      alu_flags[FLAG_Z] = (alu_res == '0);
      alu_flags[FLAG_N] = alu_res[MSB];
      alu_flags[FLAG_C] = c_n;
      alu_flags[FLAG_V] = v_n;
    end
  end

`ifdef AC_MUL_EN
  state_e             state;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   mq_q;
  logic               mul_start;
  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_last;

  assign mul_start = (state == IDLE) && AC_LOAD && (OP == OP_MUL);

  ac_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .CLK          (CLK),
    .RST          (RST),
    .start        (mul_start),
    .multiplicand (BUS_IN),
    .multiplier   (ac_q),
    .product      (mul_prod),
    .last_step    (mul_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      ac_q    <= '0;
      mq_q    <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (mul_start) begin
            state  <= MUL_RUN;
            busy_q <= 1'b1;
          end else if (AC_LOAD) begin
            ac_q    <= alu_res;
            flags_q <= alu_flags;
          end
        end
        MUL_RUN: begin
          if (mul_last) begin
            state           <= MUL_DONE;
            busy_q          <= 1'b0;
            done_q          <= 1'b1;
            ac_q            <= mul_prod[WIDTH-1:0];
            mq_q            <= mul_prod[2*WIDTH-1:WIDTH];
            flags_q[FLAG_Z] <= (mul_prod == '0);
            flags_q[FLAG_N] <= mul_prod[MSB];
            flags_q[FLAG_C] <= |mul_prod[2*WIDTH-1:WIDTH];
            flags_q[FLAG_V] <= |mul_prod[2*WIDTH-1:WIDTH];
          end
        end
        MUL_DONE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign MQ_OUT = mq_q;
`else
  always_ff @(posedge CLK) begin
    if (RST) begin
      ac_q    <= '0;
      flags_q <= '0;
    end else if (AC_LOAD) begin
      ac_q    <= alu_res;
      flags_q <= alu_flags;
    end
  end

  assign BUSY   = 1'b0;
  assign DONE   = 1'b0;
  assign MQ_OUT = '0;
`endif

  assign AC_TOCPU   = ac_q;
  assign AC_BUS_OUT = ac_q;
  assign AC_BUS_OE  = AC_BUS;
  assign Z_TOCU     = flags_q[FLAG_Z];
  assign N_TOCU     = flags_q[FLAG_N];
  assign C_TOCU     = flags_q[FLAG_C];
  assign V_TOCU     = flags_q[FLAG_V];

endmodule

// File: tb/tb_ac_unit_param.sv
// Self-checking bench for ac_unit_param (WIDTH=8); MUL scenarios run when AC_MUL_EN is defined.
module tb_ac_unit_param;
  import ac_pkg::*;

  localparam int MOD  = 256;
  localparam int HALF = 128;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] BUS_IN = '0;
  logic [3:0] OP = '0;
  logic       AC_LOAD = 1'b0;
  logic       AC_BUS = 1'b0;
  logic [7:0] AC_BUS_OUT, AC_TOCPU, MQ_OUT;
  logic       AC_BUS_OE, Z_TOCU, N_TOCU, C_TOCU, V_TOCU, BUSY, DONE;
  logic [21:0] obs;

  int checks = 0;
  int fails  = 0;

  int ac_m = 0, mq_m = 0;
  bit fz, fn, fc, fv, busy_m, done_m;

  ac_unit_param #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .BUS_IN(BUS_IN), .OP(OP), .AC_LOAD(AC_LOAD), .AC_BUS(AC_BUS),
    .AC_BUS_OUT(AC_BUS_OUT), .AC_BUS_OE(AC_BUS_OE), .AC_TOCPU(AC_TOCPU), .MQ_OUT(MQ_OUT),
    .Z_TOCU(Z_TOCU), .N_TOCU(N_TOCU), .C_TOCU(C_TOCU), .V_TOCU(V_TOCU), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  assign obs = {AC_TOCPU, MQ_OUT, Z_TOCU, N_TOCU, C_TOCU, V_TOCU, BUSY, DONE};

  function automatic int sv(input int x);
    return (x >= HALF) ? x - MOD : x;
  endfunction

  function automatic logic [21:0] exp_vec();
    return {8'(ac_m), 8'(mq_m), fz, fn, fc, fv, busy_m, done_m};
  endfunction

  // Reference model of a single-cycle load, written from the arithmetic definitions.
  task automatic model_load(input int op, input int b);
    int a, r, s;
    bit upd;
    a = ac_m; r = a; upd = 1;
    case (op)
      1:  r = b;
      2:  begin s = a + b; r = s % MOD; fc = (s >= MOD);
                fv = (sv(a) + sv(b) > HALF - 1) || (sv(a) + sv(b) < -HALF); end
      3:  begin r = (a - b + MOD) % MOD; fc = (a < b);
                fv = (sv(a) - sv(b) > HALF - 1) || (sv(a) - sv(b) < -HALF); end
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  r = (MOD - 1) - a;
      8:  begin s = a + 1; r = s % MOD; fc = (s == MOD); fv = (sv(a) + 1 > HALF - 1); end
      9:  r = 0;
      10: begin r = (a * 2) % MOD; fc = (a >= HALF); end
      11: begin r = a / 2; fc = (a % 2 == 1); end
      default: upd = 0;
    endcase
    if (upd) begin
      ac_m = r; fz = (r == 0); fn = (r >= HALF);
    end
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic load(input int op, input int b);
    AC_LOAD = 1; OP = op[3:0]; BUS_IN = b[7:0];
    step();
    model_load(op, b);
    AC_LOAD = 0;
  endtask

  task automatic test_reset();
    RST = 1; AC_LOAD = 1; OP = OP_PASS; BUS_IN = 8'hFF; AC_BUS = 0;
    step(); step();
    ac_m = 0; mq_m = 0; fz = 0; fn = 0; fc = 0; fv = 0; busy_m = 0; done_m = 0;
    checks++;
    if (obs !== exp_vec()) begin
      fails++; $display("FAIL reset_initial: got %h expected %h", obs, exp_vec());
    end
    RST = 0; BUS_IN = 8'hC3;
    step();
    RST = 1; BUS_IN = 8'hFF;
    step();
    checks++;
    if (obs !== exp_vec()) begin
      fails++; $display("FAIL reset_over_load: got %h expected %h", obs, exp_vec());
    end
    RST = 0; AC_LOAD = 0;
  endtask

  task automatic test_directed();
    int ops [14] = '{1, 2, 2, 1, 3, 4, 10, 7, 11, 8, 13, 9, 1, 8};
    int bs  [14] = '{'h7F, 'h01, 'h80, 'h05, 'h06, 'h0F, 0, 0, 0, 0, 'h55, 0, 'hFF, 0};
    int eac [14] = '{'h7F, 'h80, 'h00, 'h05, 'hFF, 'h0F, 'h1E, 'hE1, 'h70, 'h71, 'h71, 'h00, 'hFF, 'h00};
    int efl [14] = '{'h0, 'h5, 'hB, 'h3, 'h6, 'h2, 'h0, 'h4, 'h2, 'h0, 'h0, 'h8, 'h4, 'hA};
    for (int i = 0; i < 14; i++) begin
      load(ops[i], bs[i]);
      checks++;
      if ({AC_TOCPU, Z_TOCU, N_TOCU, C_TOCU, V_TOCU} !== {8'(eac[i]), 4'(efl[i])}) begin
        fails++;
        $display("FAIL directed[%0d] op=%0d: got ac=%h znvc=%b expected ac=%h zncv=%b",
                 i, ops[i], AC_TOCPU, {Z_TOCU, N_TOCU, C_TOCU, V_TOCU}, 8'(eac[i]), 4'(efl[i]));
      end
    end
  endtask

  task automatic test_alu_random();
    for (int i = 0; i < 300; i++) begin
      int op, b;
      op = $urandom_range(0, 15);
`ifdef AC_MUL_EN
      if (op == 12) op = 0;
`endif
      b = $urandom_range(0, 255);
      AC_LOAD = ($urandom_range(0, 3) != 0); OP = op[3:0]; BUS_IN = b[7:0];
      AC_BUS = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ((AC_BUS_OE !== AC_BUS) || (AC_BUS && (AC_BUS_OUT !== 8'(ac_m)))) begin
        fails++; $display("FAIL bus_rand[%0d]: got oe=%b out=%h expected oe=%b out=%h",
                          i, AC_BUS_OE, AC_BUS_OUT, AC_BUS, 8'(ac_m));
      end
      step();
      if (AC_LOAD) model_load(op, b);
      checks++;
      if (obs !== exp_vec()) begin
        fails++; $display("FAIL alu_rand[%0d] op=%0d b=%h: got %h expected %h", i, op, b, obs, exp_vec());
      end
    end
    AC_LOAD = 0; AC_BUS = 0;
  endtask

  task automatic test_bus();
    load(1, 'hA5);
    for (int i = 0; i < 6; i++) begin
      AC_BUS = ~AC_BUS;
      #2;
      checks++;
      if ((AC_BUS_OE !== AC_BUS) || (AC_BUS_OUT !== 8'hA5)) begin
        fails++; $display("FAIL bus_toggle[%0d]: got oe=%b out=%h expected oe=%b out=a5",
                          i, AC_BUS_OE, AC_BUS_OUT, AC_BUS);
      end
      step();
    end
    AC_BUS = 0;
  endtask

`ifdef AC_MUL_EN
  // Runs one MUL; optionally asserts AC_LOAD with hit_op during cycle hit_cycle (1..9).
  task automatic do_mul(input int b, input int hit_cycle, input int hit_op);
    int prod;
    prod = ac_m * b;
    AC_LOAD = 1; OP = OP_MUL; BUS_IN = b[7:0];
    step();
    AC_LOAD = 0;
    for (int i = 1; i <= 9; i++) begin
      busy_m = (i <= 8); done_m = (i == 9);
      if (i == 9) begin
        ac_m = prod % MOD; mq_m = prod / MOD;
        fz = (prod == 0); fn = (ac_m >= HALF); fc = (mq_m != 0); fv = fc;
      end
      checks++;
      if (obs !== exp_vec()) begin
        fails++; $display("FAIL mul_cycle%0d b=%h: got %h expected %h", i, b, obs, exp_vec());
      end
      BUS_IN = 8'($urandom_range(0, 255));
      AC_LOAD = (i == hit_cycle); OP = hit_op[3:0];
      step();
    end
    AC_LOAD = 0; busy_m = 0; done_m = 0;
    checks++;
    if (obs !== exp_vec()) begin
      fails++; $display("FAIL mul_after b=%h: got %h expected %h", b, obs, exp_vec());
    end
  endtask

  task automatic test_mul();
    load(1, 'h0F);
    do_mul('h11, 0, 0);
    do_mul('h10, 0, 0);
    load(1, 0);
    do_mul('h9C, 0, 0);
    for (int i = 0; i < 4; i++) begin
      load(1, $urandom_range(0, 255));
      do_mul($urandom_range(0, 255), 0, 0);
    end
  endtask

  task automatic test_collision();
    load(1, 'h3B);
    do_mul('hC7, 3, OP_CLR);
    do_mul('h05, 9, OP_MUL);
    do_mul('h81, 9, OP_PASS);
  endtask

  task automatic test_reset_abort();
    load(1, 'h37);
    AC_LOAD = 1; OP = OP_MUL; BUS_IN = 8'h5A;
    step();
    AC_LOAD = 0; busy_m = 1;
    for (int i = 1; i <= 3; i++) step();
    checks++;
    if (obs !== exp_vec()) begin
      fails++; $display("FAIL abort_pre: got %h expected %h", obs, exp_vec());
    end
    RST = 1;
    step();
    RST = 0;
    ac_m = 0; mq_m = 0; fz = 0; fn = 0; fc = 0; fv = 0; busy_m = 0; done_m = 0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        fails++; $display("FAIL abort_cycle%0d: got %h expected %h", i, obs, exp_vec());
      end
      step();
    end
  endtask
`else
  task automatic test_no_mul();
    load(1, $urandom_range(1, 255));
    for (int i = 0; i < 3; i++) begin
      load(OP_MUL, $urandom_range(0, 255));
      checks++;
      if (obs !== exp_vec()) begin
        fails++; $display("FAIL mul_as_nop[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask
`endif

  initial begin
    fz = 0; fn = 0; fc = 0; fv = 0; busy_m = 0; done_m = 0;
    test_reset();
    test_directed();
    test_alu_random();
    test_bus();
`ifdef AC_MUL_EN
    test_mul();
    test_collision();
    test_reset_abort();
`else
    test_no_mul();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
